// File: rtl/burst_enable_gen_pkg.sv
// Shared definitions for the burst enable generator: state encoding and
// default widths for the prescale and burst-length fields.
package burst_enable_gen_pkg;

    localparam int DEF_PRESCALE_W = 4;
    localparam int DEF_BURST_W    = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/burst_enable_gen_if.sv
// Control/status bundle between a burst requester (master) and the
// burst enable generator (slave).
interface burst_enable_gen_if
    import burst_enable_gen_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int BURST_W    = DEF_BURST_W
) ();

    logic                  start;
    logic                  stop;
    logic [PRESCALE_W-1:0] prescale;
    logic [BURST_W-1:0]    burst_len;
    logic                  enable;
    logic                  busy;
    logic                  done;

    modport master (
        output start, stop, prescale, burst_len,
        input  enable, busy, done
    );

    modport slave (
        input  start, stop, prescale, burst_len,
        output enable, busy, done
    );

endinterface

// File: rtl/burst_enable_gen_prescale_tick.sv
// Prescaler: counts 0..period and wraps. tick flags the cycle in which the
// count sits at period, i.e. the edge that closes one period. While clear
// is high the count is held at 0 so a new burst always starts aligned.
module prescale_tick
    import burst_enable_gen_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] period,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] count_reg;

    // Period counter, restarted from 0 on clear or on reaching period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear || (count_reg == period)) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tick = !clear && (count_reg == period);

endmodule

// File: rtl/burst_enable_gen.sv
// Burst enable generator: after start, issues burst_len one-cycle enable
// pulses spaced prescale+1 clocks apart (burst_len = 0 runs until stop),
// then strobes done for one cycle. All outputs come straight from flops.
module burst_enable_gen
    import burst_enable_gen_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int BURST_W    = DEF_BURST_W
) (
    input  logic              clock,
    input  logic              reset,
    burst_enable_gen_if.slave bus
);

    state_t                state_reg, state_next;
    logic [PRESCALE_W-1:0] period_reg, period_next;
    logic [BURST_W-1:0]    len_reg, len_next;
    logic [BURST_W-1:0]    pulse_cnt_reg, pulse_cnt_next;
    logic                  enable_reg, enable_next;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  tick;
    logic                  tick_clear;
    logic                  burst_complete;

    assign tick_clear = (state_reg != RUN);

    prescale_tick #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescale_tick (
        .clock  (clock),
        .reset  (reset),
        .clear  (tick_clear),
        .period (period_reg),
        .tick   (tick)
    );

    // The L-th pulse has been issued; the cycle after its enable we leave RUN,
    // so the last enable cycle still shows busy and done follows it directly.
    assign burst_complete = (len_reg != '0) && (pulse_cnt_reg == len_reg);

    // Next-state and pulse decisions; stop has priority over a due pulse.
    always_comb begin
        state_next     = state_reg;
        period_next    = period_reg;
        len_next       = len_reg;
        pulse_cnt_next = pulse_cnt_reg;
        enable_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_next     = RUN;
                    period_next    = bus.prescale;
                    len_next       = bus.burst_len;
                    pulse_cnt_next = '0;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_next = IDLE;
                end else if (burst_complete) begin
                    state_next = DONE;
                end else if (tick) begin
                    enable_next    = 1'b1;
                    pulse_cnt_next = pulse_cnt_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, captured parameters, pulse counter and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            period_reg    <= '0;
            len_reg       <= '0;
            pulse_cnt_reg <= '0;
            enable_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            period_reg    <= period_next;
            len_reg       <= len_next;
            pulse_cnt_reg <= pulse_cnt_next;
            enable_reg    <= enable_next;
            busy_reg      <= (state_next == RUN);
            done_reg      <= (state_next == DONE);
        end
    end

    assign bus.enable = enable_reg;
    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;

endmodule
